// File: rtl/mult_seq_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mult_seq_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    CALC = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_e;

  // Counter must reach WIDTH itself, hence one bit beyond clog2.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/mult_seq_datapath.sv
// Operand/accumulator registers and the shift-add adder for mult_seq_ctrl.
module mult_seq_datapath
  import mult_seq_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned EARLY_TERM = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load,
  input  logic                          calc,
  input  logic                          fix,
  input  logic                          signed_mode,
  input  logic [WIDTH-1:0]              a_in,
  input  logic [WIDTH-1:0]              b_in,
  output logic [2*WIDTH-1:0]            product_out,
  output logic [cnt_width(WIDTH)-1:0]   cnt_out,
  output logic                          calc_last
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = cnt_width(WIDTH);

  logic [PW-1:0]    mcand_q, acc_q, product_q;
  logic [WIDTH-1:0] mplier_q, a_mag, b_mag;
  logic [CW-1:0]    cnt_q;
  logic             neg_q;

  // The most-negative input negates to itself, which read unsigned is its magnitude.
  assign a_mag = (signed_mode && a_in[WIDTH-1]) ? -a_in : a_in;
  assign b_mag = (signed_mode && b_in[WIDTH-1]) ? -b_in : b_in;

  assign calc_last = (cnt_q == CW'(WIDTH - 1)) ||
                     ((EARLY_TERM != 0) && (mplier_q[WIDTH-1:1] == '0));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand_q   <= '0;
      acc_q     <= '0;
      product_q <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
    end else begin
      if (load) begin
        mcand_q  <= {{WIDTH{1'b0}}, a_mag};
        mplier_q <= b_mag;
        acc_q    <= '0;
        cnt_q    <= '0;
        neg_q    <= signed_mode & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
      end else if (calc) begin
        acc_q    <= acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + CW'(1);
      end
      if (fix) begin
        product_q <= neg_q ? -acc_q : acc_q;
      end
    end
  end

  assign product_out = product_q;
  assign cnt_out     = cnt_q;

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequential shift-add multiplier: start/done handshake, signed mode, optional early exit.
module mult_seq_ctrl
  import mult_seq_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned EARLY_TERM = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          signed_mode,
  input  logic [WIDTH-1:0]              a_in,
  input  logic [WIDTH-1:0]              b_in,
  output logic [2*WIDTH-1:0]            product_out,
  output logic                          done_out,
  output logic                          busy_out,
  output logic                          load_out,
  output logic [cnt_width(WIDTH)-1:0]   cnt_out,
  output logic [STATE_W-1:0]            ps_out,
  output logic [STATE_W-1:0]            ns_out
);

  state_e ps_q, ns;
  logic   done_q, busy_q, load_q, mode_q;
  logic   calc_last;

  always_comb begin
    ns = IDLE;
    case (ps_q)
      IDLE:    ns = start ? LOAD : IDLE;
      LOAD:    ns = CALC;
      CALC:    ns = calc_last ? FIX : CALC;
      FIX:     ns = DONE;
      DONE:    ns = IDLE;
      default: ns = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with ps_q.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ps_q   <= IDLE;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      load_q <= 1'b0;
      mode_q <= 1'b0;
    end else begin
      ps_q   <= ns;
      done_q <= (ns == DONE);
      busy_q <= (ns != IDLE);
      load_q <= (ns == LOAD);
      if (ps_q == IDLE && start) begin
        mode_q <= signed_mode;
      end
    end
  end

  mult_seq_datapath #(
    .WIDTH      (WIDTH),
    .EARLY_TERM (EARLY_TERM)
  ) u_datapath (
    .clk         (clk),
    .reset       (reset),
    .load        (ps_q == LOAD),
    .calc        (ps_q == CALC),
    .fix         (ps_q == FIX),
    .signed_mode (mode_q),
    .a_in        (a_in),
    .b_in        (b_in),
    .product_out (product_out),
    .cnt_out     (cnt_out),
    .calc_last   (calc_last)
  );

  assign done_out = done_q;
  assign busy_out = busy_q;
  assign load_out = load_q;
  assign ps_out   = ps_q;
  assign ns_out   = ns;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench: one DUT with full-length CALC, one with early termination, shared stimulus.
module tb_mult_seq_ctrl;

  logic        clk, reset, start, signed_mode;
  logic [7:0]  a_in, b_in;
  logic [15:0] prod0, prod1;
  logic        done0, done1, busy0, busy1, load0, load1;
  logic [3:0]  cnt0, cnt1;
  logic [2:0]  ps0, ps1, ns0, ns1;

  int n_pass = 0;
  int n_total = 0;

  int d0_cyc, d1_cyc, d0_n, d1_n, b0_n, b1_n, l0_n;
  logic [2:0] seq0 [0:15];
  logic [2:0] exp_seq [0:12] = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2,
                                 3'd2, 3'd3, 3'd4, 3'd0};

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        m;
    logic [15:0] p;
    int          n;
  } vec_t;
  vec_t vecs [8];

  mult_seq_ctrl #(.WIDTH(8), .EARLY_TERM(0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .signed_mode(signed_mode),
    .a_in(a_in), .b_in(b_in), .product_out(prod0), .done_out(done0),
    .busy_out(busy0), .load_out(load0), .cnt_out(cnt0), .ps_out(ps0), .ns_out(ns0)
  );

  mult_seq_ctrl #(.WIDTH(8), .EARLY_TERM(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .signed_mode(signed_mode),
    .a_in(a_in), .b_in(b_in), .product_out(prod1), .done_out(done1),
    .busy_out(busy1), .load_out(load1), .cnt_out(cnt1), .ps_out(ps1), .ns_out(ns1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  // Start one op, then watch 14 cycles; noise pokes start/operands while busy.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic m,
                        input bit noise);
    @(negedge clk);
    a_in = a; b_in = b; signed_mode = m; start = 1'b1;
    seq0[0] = ps0;
    d0_cyc = 0; d1_cyc = 0; d0_n = 0; d1_n = 0; b0_n = 0; b1_n = 0; l0_n = 0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      seq0[c] = ps0;
      if (done0) begin d0_n++; if (d0_cyc == 0) d0_cyc = c; end
      if (done1) begin d1_n++; if (d1_cyc == 0) d1_cyc = c; end
      if (busy0) b0_n++;
      if (busy1) b1_n++;
      if (load0) l0_n++;
      start = 1'b0;
      if (noise && c >= 2 && c <= 7) begin
        start = c[0]; a_in = 8'hFF; b_in = 8'hFF; signed_mode = 1'b1;
      end
    end
  endtask

  initial begin
    logic [2:0] prev0;
    reset = 1'b0; start = 1'b0; signed_mode = 1'b0; a_in = '0; b_in = '0;
    vecs[0] = '{8'd13,  8'd11,  1'b0, 16'h008F, 4};
    vecs[1] = '{8'hFD,  8'd5,   1'b1, 16'hFFF1, 3};
    vecs[2] = '{8'h80,  8'h80,  1'b1, 16'h4000, 8};
    vecs[3] = '{8'hFF,  8'hFF,  1'b0, 16'hFE01, 8};
    vecs[4] = '{8'd200, 8'd1,   1'b0, 16'h00C8, 1};
    vecs[5] = '{8'd200, 8'd0,   1'b0, 16'h0000, 1};
    vecs[6] = '{8'hFF,  8'hFF,  1'b1, 16'h0001, 1};
    vecs[7] = '{8'h7F,  8'h80,  1'b1, 16'hC080, 8};

    // Reset state
    @(negedge clk); @(negedge clk);
    check("rst ps0", 32'(ps0), 0);
    check("rst ps1", 32'(ps1), 0);
    check("rst prod0", 32'(prod0), 0);
    check("rst cnt0", 32'(cnt0), 0);
    check("rst busy0", 32'(busy0), 0);
    check("rst done0", 32'(done0), 0);
    check("rst load0", 32'(load0), 0);
    check("rst ns0", 32'(ns0), 0);
    reset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].m, 1'b0);
      check($sformatf("v%0d prod0", i), 32'(prod0), 32'(vecs[i].p));
      check($sformatf("v%0d prod1", i), 32'(prod1), 32'(vecs[i].p));
      check($sformatf("v%0d done0 cycle", i), d0_cyc, 11);
      check($sformatf("v%0d done1 cycle", i), d1_cyc, vecs[i].n + 3);
      check($sformatf("v%0d done0 pulses", i), d0_n, 1);
      check($sformatf("v%0d done1 pulses", i), d1_n, 1);
      check($sformatf("v%0d busy0 cycles", i), b0_n, 11);
      check($sformatf("v%0d busy1 cycles", i), b1_n, vecs[i].n + 3);
      check($sformatf("v%0d load0 cycles", i), l0_n, 1);
      check($sformatf("v%0d cnt0", i), 32'(cnt0), 8);
      check($sformatf("v%0d cnt1", i), 32'(cnt1), vecs[i].n);
      if (i == 0)
        for (int c = 0; c <= 12; c++)
          check($sformatf("ps seq[%0d]", c), 32'(seq0[c]), 32'(exp_seq[c]));
    end

    // start held high: back-to-back 7*6
    @(negedge clk);
    a_in = 8'd7; b_in = 8'd6; signed_mode = 1'b0; start = 1'b1;
    #1 check("ns idle+start", 32'(ns0), 1);
    prev0 = ps0; d0_n = 0; d1_n = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (done0) begin d0_n++; check("bb prod0", 32'(prod0), 42); end
      if (done1) begin d1_n++; check("bb prod1", 32'(prod1), 42); end
      if (prev0 == 3'd4) check("bb done->idle", 32'(ps0), 0);
      if (prev0 == 3'd0 && ps0 != 3'd0) check("bb idle->load", 32'(ps0), 1);
      prev0 = ps0;
      if (c == 19) start = 1'b0;
    end
    check("bb done0 count", d0_n, 2);
    check("bb done1 count", d1_n, 3);

    // Reset mid-CALC
    @(negedge clk);
    a_in = 8'h55; b_in = 8'h33; signed_mode = 1'b0; start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("pre-rst ps0 calc", 32'(ps0), 2);
    check("pre-rst prod0 hold", 32'(prod0), 42);
    reset = 1'b0;
    #1;
    check("mid-rst ps0", 32'(ps0), 0);
    check("mid-rst ps1", 32'(ps1), 0);
    check("mid-rst prod0", 32'(prod0), 0);
    check("mid-rst prod1", 32'(prod1), 0);
    check("mid-rst cnt0", 32'(cnt0), 0);
    check("mid-rst busy0", 32'(busy0), 0);
    d0_n = 0; d1_n = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done0) d0_n++;
      if (done1) d1_n++;
    end
    check("rst no done0", d0_n, 0);
    check("rst no done1", d1_n, 0);
    reset = 1'b1;
    run_op(8'd9, 8'd9, 1'b0, 1'b0);
    check("post-rst prod0", 32'(prod0), 81);
    check("post-rst prod1", 32'(prod1), 81);
    check("post-rst done0", d0_n, 1);

    // start and operands toggled while busy are ignored
    run_op(8'd10, 8'd12, 1'b0, 1'b1);
    check("noise prod0", 32'(prod0), 120);
    check("noise prod1", 32'(prod1), 120);
    check("noise done0 cycle", d0_cyc, 11);
    check("noise done1 cycle", d1_cyc, 7);
    check("noise done0 pulses", d0_n, 1);
    check("noise done1 pulses", d1_n, 1);
    check("noise ps0 idle", 32'(ps0), 0);
    check("noise ps1 idle", 32'(ps1), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
